inst_fetch_ctrl: RTL and testbench

Sequencer for the instruction-fetch path of the single-cycle CPU lab board. Owns the program counter and issues word reads to the instruction ROM over a req/ack handshake, in single-step (button) or free-run mode, with jump-target load. Captures the fetched 32-bit instruction and drives an 8-bit LED byte view of it. Sits between the debounced board buttons and the instruction ROM; replaces free-running PC logic.

---
 rtl/inst_fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - PC owner and ROM fetch sequencer with LED byte view.
// Define INST_LED_AUTOSCAN_EN to rotate LED lanes every SCAN_DIV cycles instead of following Sel.
module inst_fetch_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int SCAN_DIV = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Step,
  input  logic              Run,
  input  logic              Jmp_En,
  input  logic [ADDR_W-1:0] Jmp_Addr,
  output logic              Rom_Req,
  output logic [ADDR_W-3:0] Rom_Addr,
  input  logic              Rom_Ack,
  input  logic [31:0]       Rom_Data,
  output logic [31:0]       Inst_Code,
  output logic              Inst_Valid,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  input  logic [1:0]        Sel,
  output logic [1:0]        Lane,
  output logic [7:0]        LED
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state;
  logic              step_pend;
  logic              jmp_pend;
  logic [ADDR_W-1:0] jmp_tgt;
  logic [ADDR_W-1:0] jmp_word;

  assign jmp_word = {Jmp_Addr[ADDR_W-1:2], 2'b00};
  assign Rom_Addr = PC[ADDR_W-1:2];

  // PC only moves outside REQ, so Rom_Addr is stable for the whole request.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= IDLE;
      PC         <= '0;
      Inst_Code  <= '0;
      Inst_Valid <= 1'b0;
      Rom_Req    <= 1'b0;
      Busy       <= 1'b0;
      step_pend  <= 1'b0;
      jmp_pend   <= 1'b0;
      jmp_tgt    <= '0;
    end else begin
      Inst_Valid <= 1'b0;
      case (state)
        IDLE: begin
          if (Jmp_En) begin
            PC <= jmp_word;
          end else if (Step || Run) begin
            state   <= REQ;
            Rom_Req <= 1'b1;
            Busy    <= 1'b1;
          end
        end
        REQ: begin
          if (Step) step_pend <= 1'b1;
          if (Rom_Ack) begin
            state      <= DONE;
            Rom_Req    <= 1'b0;
            Inst_Code  <= Rom_Data;
            Inst_Valid <= 1'b1;
            jmp_pend   <= 1'b0;
            if (Jmp_En)        PC <= jmp_word;
            else if (jmp_pend) PC <= jmp_tgt;
            else               PC <= PC + ADDR_W'(4);
          end else if (Jmp_En) begin
            jmp_pend <= 1'b1;
            jmp_tgt  <= jmp_word;
          end
        end
        DONE: begin
          step_pend <= 1'b0;
          if (Run || step_pend || Step) begin
            state   <= REQ;
            Rom_Req <= 1'b1;
            if (Jmp_En) begin
              jmp_pend <= 1'b1;
              jmp_tgt  <= jmp_word;
            end
          end else begin
            state <= IDLE;
            Busy  <= 1'b0;
            if (Jmp_En) PC <= jmp_word;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INST_LED_AUTOSCAN_EN
  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      div_cnt <= '0;
      Lane    <= 2'd0;
    end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
      div_cnt <= '0;
      Lane    <= Lane + 2'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end
`else
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) Lane <= 2'd0;
    else      Lane <= Sel;
  end
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) LED <= 8'h00;
    else      LED <= Inst_Code[8*Lane +: 8];
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - directed bench for inst_fetch_ctrl (default build, ADDR_W=8).
module tb_inst_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Step = 1'b0;
  logic        Run = 1'b0;
  logic        Jmp_En = 1'b0;
  logic [7:0]  Jmp_Addr = 8'h00;
  logic        Rom_Req;
  logic [5:0]  Rom_Addr;
  logic        Rom_Ack = 1'b0;
  logic [31:0] Rom_Data = 32'h0;
  logic [31:0] Inst_Code;
  logic        Inst_Valid;
  logic [7:0]  PC;
  logic        Busy;
  logic [1:0]  Sel = 2'd0;
  logic [1:0]  Lane;
  logic [7:0]  LED;

  int total = 0;
  int bad = 0;

  inst_fetch_ctrl #(.ADDR_W(8), .SCAN_DIV(16)) dut (
    .Clk(Clk), .Rst(Rst), .Step(Step), .Run(Run), .Jmp_En(Jmp_En),
    .Jmp_Addr(Jmp_Addr), .Rom_Req(Rom_Req), .Rom_Addr(Rom_Addr),
    .Rom_Ack(Rom_Ack), .Rom_Data(Rom_Data), .Inst_Code(Inst_Code),
    .Inst_Valid(Inst_Valid), .PC(PC), .Busy(Busy), .Sel(Sel),
    .Lane(Lane), .LED(LED)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_pc;
    #12;
    check("rst_pc", 32'(PC), 32'h0);
    check("rst_code", Inst_Code, 32'h0);
    check("rst_valid", 32'(Inst_Valid), 32'h0);
    check("rst_req", 32'(Rom_Req), 32'h0);
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst_led", 32'(LED), 32'h0);
    check("rst_lane", 32'(Lane), 32'h0);
    @(negedge Clk);
    Rst = 1'b1;
    tick();

    // single step, ROM acks on the third REQ cycle
    Step = 1'b1;
    tick();
    Step = 1'b0;
    check("s1_req", 32'(Rom_Req), 32'h1);
    check("s1_addr", 32'(Rom_Addr), 32'h0);
    check("s1_busy", 32'(Busy), 32'h1);
    tick();
    check("s1_req_hold", 32'(Rom_Req), 32'h1);
    tick();
    check("s1_req_hold2", 32'(Rom_Req), 32'h1);
    check("s1_no_valid", 32'(Inst_Valid), 32'h0);
    Rom_Ack = 1'b1;
    Rom_Data = 32'h2001_0005;
    tick();
    Rom_Ack = 1'b0;
    check("s1_valid", 32'(Inst_Valid), 32'h1);
    check("s1_code", Inst_Code, 32'h2001_0005);
    check("s1_pc", 32'(PC), 32'h4);
    check("s1_req_drop", 32'(Rom_Req), 32'h0);
    check("s1_busy_done", 32'(Busy), 32'h1);
    tick();
    check("s1_valid_pulse", 32'(Inst_Valid), 32'h0);
    check("s1_idle_busy", 32'(Busy), 32'h0);
    check("s1_led", 32'(LED), 32'h05);
    tick();
    check("s1_idle_req", 32'(Rom_Req), 32'h0);

    // jump in IDLE with a simultaneous Step drops the Step
    Jmp_En = 1'b1;
    Jmp_Addr = 8'h23;
    Step = 1'b1;
    tick();
    Jmp_En = 1'b0;
    Step = 1'b0;
    check("j_idle_pc", 32'(PC), 32'h20);
    check("j_idle_req", 32'(Rom_Req), 32'h0);
    tick();
    check("j_idle_req2", 32'(Rom_Req), 32'h0);
    check("j_idle_busy", 32'(Busy), 32'h0);

    // jump during REQ is deferred until the in-flight fetch completes
    Jmp_En = 1'b1;
    Jmp_Addr = 8'h08;
    tick();
    Jmp_En = 1'b0;
    check("j_pc8", 32'(PC), 32'h08);
    Step = 1'b1;
    tick();
    Step = 1'b0;
    check("jr_addr", 32'(Rom_Addr), 32'h2);
    Jmp_En = 1'b1;
    Jmp_Addr = 8'h40;
    tick();
    Jmp_En = 1'b0;
    check("jr_addr_hold", 32'(Rom_Addr), 32'h2);
    check("jr_pc_hold", 32'(PC), 32'h08);
    Rom_Ack = 1'b1;
    Rom_Data = 32'h1111_2222;
    tick();
    Rom_Ack = 1'b0;
    check("jr_code", Inst_Code, 32'h1111_2222);
    check("jr_pc", 32'(PC), 32'h40);
    tick();
    check("jr_idle", 32'(Busy), 32'h0);

    // two Steps during one REQ give exactly one extra fetch
    Step = 1'b1;
    tick();
    tick();
    tick();
    Step = 1'b0;
    check("ss_req", 32'(Rom_Req), 32'h1);
    Rom_Ack = 1'b1;
    Rom_Data = 32'h0BAD_F00D;
    tick();
    Rom_Ack = 1'b0;
    check("ss_pc1", 32'(PC), 32'h44);
    tick();
    check("ss_req2", 32'(Rom_Req), 32'h1);
    check("ss_addr2", 32'(Rom_Addr), 32'h11);
    Rom_Ack = 1'b1;
    Rom_Data = 32'hA1B2_C3D4;
    tick();
    Rom_Ack = 1'b0;
    check("ss_pc2", 32'(PC), 32'h48);
    check("ss_code2", Inst_Code, 32'hA1B2_C3D4);
    tick();
    check("ss_idle_req", 32'(Rom_Req), 32'h0);
    check("ss_idle_busy", 32'(Busy), 32'h0);
    tick();
    check("ss_no_third", 32'(Rom_Req), 32'h0);

    // LED byte lane select
    Sel = 2'd2;
    tick();
    tick();
    check("led_lane2", 32'(Lane), 32'h2);
    check("led_b2", 32'(LED), 32'hB2);
    Sel = 2'd3;
    tick();
    tick();
    check("led_a1", 32'(LED), 32'hA1);
    Sel = 2'd0;
    tick();
    tick();
    check("led_d4", 32'(LED), 32'hD4);

    // free run with zero-wait ROM across the PC wrap
    Jmp_En = 1'b1;
    Jmp_Addr = 8'h00;
    tick();
    Jmp_En = 1'b0;
    Run = 1'b1;
    Rom_Ack = 1'b1;
    tick();
    for (int i = 0; i < 64; i++) begin
      check($sformatf("run_req_%0d", i), 32'(Rom_Req), 32'h1);
      check($sformatf("run_addr_%0d", i), 32'(Rom_Addr), 32'(i));
      check($sformatf("run_nv_%0d", i), 32'(Inst_Valid), 32'h0);
      Rom_Data = 32'hC0DE_0000 | 32'(i);
      tick();
      exp_pc = 8'((i + 1) * 4);
      check($sformatf("run_v_%0d", i), 32'(Inst_Valid), 32'h1);
      check($sformatf("run_pc_%0d", i), 32'(PC), 32'(exp_pc));
      check($sformatf("run_code_%0d", i), Inst_Code, 32'hC0DE_0000 | 32'(i));
      tick();
    end
    check("run_wrap_addr", 32'(Rom_Addr), 32'h0);
    check("run_wrap_req", 32'(Rom_Req), 32'h1);
    Run = 1'b0;
    tick();
    check("run_stop_done", 32'(Inst_Valid), 32'h1);
    tick();
    Rom_Ack = 1'b0;
    check("run_stop_idle", 32'(Busy), 32'h0);
    check("run_stop_req", 32'(Rom_Req), 32'h0);

    // asynchronous reset in the middle of a request
    Jmp_En = 1'b1;
    Jmp_Addr = 8'h10;
    tick();
    Jmp_En = 1'b0;
    Step = 1'b1;
    tick();
    Step = 1'b0;
    check("ar_req_before", 32'(Rom_Req), 32'h1);
    #2;
    Rst = 1'b0;
    #1;
    check("ar_req", 32'(Rom_Req), 32'h0);
    check("ar_pc", 32'(PC), 32'h0);
    check("ar_valid", 32'(Inst_Valid), 32'h0);
    check("ar_busy", 32'(Busy), 32'h0);
    check("ar_code", Inst_Code, 32'h0);
    tick();
    Rst = 1'b1;
    tick();
    check("ar_after_req", 32'(Rom_Req), 32'h0);
    check("ar_after_valid", 32'(Inst_Valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
